// File: rtl/data_mem_ctrl.sv
// Single-port word memory with a power-up clear sequence, byte-lane writes,
// a pipelined read path of configurable latency and an out-of-range error counter.
module data_mem_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 16384,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done,
    output logic [7:0]        err_count
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        StClear,
        StRun
    } state_e;

    state_e            state_q;
    logic [IDX_W-1:0]  clr_ptr_q;

    // Memory contents are never reset; only the clear sequence zeroes them.
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              rd_accept;
    logic              wr_accept;
    logic              addr_in_range;
    logic [IDX_W-1:0]  addr_idx;
    logic              clear_we;
    logic [DATA_W-1:0] rd_word;

    logic [RD_LAT-1:0] pipe_valid_q;
    logic [RD_LAT-1:0] pipe_err_q;
    logic [DATA_W-1:0] pipe_data_q [RD_LAT];

    assign accept    = req_valid && req_ready;
    assign rd_accept = accept && !req_we;
    assign wr_accept = accept && req_we;

    // Compare the whole address so that high bits never alias into the array.
    assign addr_in_range = (64'(req_addr) < 64'(DEPTH));
    // Index is only used when addr_in_range holds, so dropping upper bits is safe.
    assign addr_idx      = req_addr[IDX_W-1:0];

    assign clear_we = (state_q == StClear) && !rst;

    // Control FSM: clear one word per cycle, then open the request port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StClear;
            clr_ptr_q <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
        end else begin
            case (state_q)
                StClear: begin
                    if (clr_ptr_q == IDX_W'(DEPTH - 1)) begin
                        state_q   <= StRun;
                        req_ready <= 1'b1;
                        init_done <= 1'b1;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + 1'b1;
                    end
                end
                StRun: begin
                    req_ready <= 1'b1;
                    init_done <= 1'b1;
                end
            endcase
        end
    end

    // Memory write port: clear writes in StClear, byte-masked writes in StRun.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clr_ptr_q] <= '0;
        end else if (wr_accept && addr_in_range) begin
            for (int i = 0; i < BE_W; i++) begin
                if (req_be[i]) begin
                    mem[addr_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read word for the first pipeline stage; forced to zero unless it is a valid read.
    always_comb begin
        rd_word = '0;
        if (rd_accept && addr_in_range) begin
            rd_word = mem[addr_idx];
        end
    end

    // Read pipeline: stage 0 captures at acceptance, the last stage drives the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid_q <= '0;
            pipe_err_q   <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_data_q[i] <= '0;
            end
        end else begin
            pipe_valid_q[0] <= rd_accept;
            pipe_err_q[0]   <= rd_accept && !addr_in_range;
            pipe_data_q[0]  <= rd_word;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_err_q[i]   <= pipe_err_q[i-1];
                pipe_data_q[i]  <= pipe_data_q[i-1];
            end
        end
    end

    // Non-valid slots carry zero data and error, so outputs are quiet between responses.
    assign rsp_valid = pipe_valid_q[RD_LAT-1];
    assign rsp_err   = pipe_err_q[RD_LAT-1];
    assign rsp_rdata = pipe_data_q[RD_LAT-1];

    // Saturating count of accepted out-of-range requests, reads and writes alike.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (accept && !addr_in_range && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: behavioural model with per-cycle compare plus directed literal checks.
module tb_data_mem_ctrl;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 1000;
    localparam int ADDR_W = 10;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_be;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              init_done;
    logic [7:0]        err_count;

    always #5 clk = ~clk;

    data_mem_ctrl #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .init_done(init_done),
        .err_count(err_count)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        logic [15:0] data;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [15:0] model_mem [DEPTH];
    int          edge_cnt  = 0;
    bit          live      = 1'b0;
    int          since_rst = 0;
    bit          m_ready   = 1'b0;
    int          m_err     = 0;

    always @(posedge clk) begin
        edge_cnt++;
        if (rst) begin
            live      = 1'b1;
            since_rst = 0;
            m_ready   = 1'b0;
            m_err     = 0;
            exp_q.delete();
        end else if (live) begin
            if (m_ready && req_valid) begin
                bit in_rng;
                in_rng = (int'(req_addr) < DEPTH);
                if (!in_rng && m_err < 255) m_err++;
                if (req_we) begin
                    if (in_rng)
                        for (int b = 0; b < 2; b++)
                            if (req_be[b]) model_mem[req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                end else begin
                    rsp_t r;
                    r.due  = edge_cnt + RD_LAT - 1;
                    r.data = in_rng ? model_mem[req_addr] : 16'h0000;
                    r.err  = !in_rng;
                    exp_q.push_back(r);
                end
            end
            if (!m_ready) begin
                since_rst++;
                if (since_rst == DEPTH) begin
                    m_ready = 1'b1;
                    for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0000;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            logic        ev;
            logic        ee;
            logic [15:0] ed;
            ev = 1'b0;
            ee = 1'b0;
            ed = 16'h0000;
            if (exp_q.size() > 0 && exp_q[0].due == edge_cnt) begin
                ev = 1'b1;
                ee = exp_q[0].err;
                ed = exp_q[0].data;
                void'(exp_q.pop_front());
            end
            check("cyc_rsp{valid,err,data}", {rsp_valid, rsp_err, rsp_rdata}, {ev, ee, ed});
            check("cyc_ctrl{ready,init,errcnt}", {req_ready, init_done, err_count},
                  {m_ready, m_ready, 8'(m_err)});
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_init(output int low_cnt, output int nrsp);
        bit done;
        done    = 1'b0;
        low_cnt = 0;
        nrsp    = 0;
        for (int k = 0; k < 1100; k++) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
            if (!done) begin
                if (req_ready) done = 1'b1;
                else low_cnt++;
            end
        end
        if (!done) check("init_timeout", 64'(done), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [9:0] a, input logic [15:0] d, input logic [1:0] be);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic do_read(input logic [9:0] a, output logic [15:0] d, output logic e,
                           output int lat);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        req_be    = 2'b00;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1;
        d   = 16'hxxxx;
        e   = 1'bx;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (lat < 0 && rsp_valid) begin
                lat = k;
                d   = rsp_rdata;
                e   = rsp_err;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic burst_123();
        logic [15:0] got [3];
        int n;
        int first;
        int last;
        n = 0;
        first = -1;
        last = -1;
        for (int i = 0; i < 3; i++) got[i] = 16'hxxxx;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 10'd1;
        fork
            begin
                @(posedge clk); #1; req_addr = 10'd2;
                @(posedge clk); #1; req_addr = 10'd3;
                @(posedge clk); #1; req_valid = 1'b0;
            end
            begin
                for (int k = 1; k <= 7; k++) begin
                    @(negedge clk);
                    if (rsp_valid) begin
                        if (n < 3) got[n] = rsp_rdata;
                        if (n == 0) first = k;
                        last = k;
                        n++;
                    end
                end
            end
        join
        @(posedge clk); #1;
        check("burst_count", 64'(n), 64'd3);
        check("burst_consecutive", 64'(last - first), 64'd2);
        check("burst_d1", got[0], 16'h0001);
        check("burst_d2", got[1], 16'h0002);
        check("burst_d3", got[2], 16'h0003);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          cnt;
        int          nrsp;
        int          lat;
        logic [15:0] d;
        logic        e;
        int          r;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_ready", req_ready, 1'b0);
        check("reset_init_done", init_done, 1'b0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        rst = 1'b0;

        wait_init(cnt, nrsp);
        check("clear_cycles", 64'(cnt), 64'd1000);
        check("init_done_after_clear", init_done, 1'b1);
        check("err_count_start", err_count, 8'd0);

        do_read(10'd999, d, e, lat);
        check("rd999_lat", 64'(lat), 64'd2);
        check("rd999_data", d, 16'h0000);
        check("rd999_err", e, 1'b0);

        do_write(10'd5, 16'hBEEF, 2'b11);
        do_write(10'd5, 16'h1234, 2'b01);
        do_read(10'd5, d, e, lat);
        check("be_merge_lat", 64'(lat), 64'd2);
        check("be_merge_data", d, 16'hBE34);

        do_write(10'd7, 16'hFFFF, 2'b00);
        do_read(10'd7, d, e, lat);
        check("be_zero_nochange", d, 16'h0000);

        do_write(10'd1, 16'h0001, 2'b11);
        do_write(10'd2, 16'h0002, 2'b11);
        do_write(10'd3, 16'h0003, 2'b11);
        burst_123();

        do_read(10'd1000, d, e, lat);
        check("oor_rd_err", e, 1'b1);
        check("oor_rd_data", d, 16'h0000);
        check("oor_rd_lat", 64'(lat), 64'd2);
        do_write(10'd1023, 16'hDEAD, 2'b11);
        check("err_count_two", err_count, 8'd2);
        do_read(10'd999, d, e, lat);
        check("rd999_unchanged", d, 16'h0000);

        // Reset right after a read is accepted: its response must never appear.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 10'd5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrd_init_done_low", init_done, 1'b0);
        check("midrd_err_count_zero", err_count, 8'd0);
        wait_init(cnt, nrsp);
        check("midrd_no_rsp", 64'(nrsp), 64'd0);
        check("midrd_clear_cycles", 64'(cnt), 64'd1000);
        do_read(10'd5, d, e, lat);
        check("midrd_addr5_cleared", d, 16'h0000);

        // Randomised traffic concentrated on a few hot addresses and the range boundary.
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_we    = 1'($urandom_range(0, 1));
            r         = $urandom_range(0, 9);
            if (r < 6)      req_addr = 10'($urandom_range(0, 15));
            else if (r < 8) req_addr = 10'($urandom_range(990, 1023));
            else            req_addr = 10'($urandom_range(0, 1023));
            req_wdata = 16'($urandom);
            req_be    = 2'($urandom);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = 10'($urandom_range(1000, 1023));
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("err_sat_255", err_count, 8'd255);
        do_write(10'd1010, 16'h5555, 2'b11);
        do_read(10'd1001, d, e, lat);
        check("err_hold_255", err_count, 8'd255);
        check("err_hold_rd_err", e, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not reach the summary, expected finish");
        $fatal(1, "timeout");
    end

endmodule
